// File: rtl/logicnet_pkg.sv
// Shared LogicNet definitions: activation code width, code type and the 2-bit
// threshold quantizer used by the input packer and hidden-layer re-quantization.
package logicnet_pkg;

    localparam int unsigned ACT_BITS = 2;

    typedef logic [ACT_BITS-1:0] act_code_t;

    // Unsigned compare against three ascending thresholds gives a code 0..3.
    function automatic act_code_t quantize2(input logic [31:0] x, input logic [31:0] t1,
                                            input logic [31:0] t2, input logic [31:0] t3);
        act_code_t c;
        c = act_code_t'(x >= t1) + act_code_t'(x >= t2) + act_code_t'(x >= t3);
        return c;
    endfunction

endpackage

// File: rtl/logicnet_quantizer2.sv
// Combinational 2-bit quantizer: maps an unsigned IN_WIDTH value to an activation
// code by comparing against thresholds T1 < T2 < T3.
module logicnet_quantizer2
    import logicnet_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned T1       = 64,
    parameter int unsigned T2       = 128,
    parameter int unsigned T3       = 192
) (
    input  logic [IN_WIDTH-1:0] x,
    output act_code_t           code
);

    assign code = quantize2(32'(x), T1, T2, T3);

endmodule

// File: rtl/logicnet_input_packer.sv
// Quantizes a stream of raw features and packs each sample into one activation vector.
// Define INPUT_PACKER_FRAME_CHECK_EN to enforce s_last framing and drive frame_err.
module logicnet_input_packer
    import logicnet_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = 16,
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned T1           = 64,
    parameter int unsigned T2           = 128,
    parameter int unsigned T3           = 192
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [IN_WIDTH-1:0]              s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ACT_BITS*NUM_FEATURES-1:0] m_data,
    output logic                             frame_err,
    output logic [15:0]                      frame_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_FEATURES);
    localparam int unsigned VEC_W = ACT_BITS * NUM_FEATURES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    act_code_t        code;
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [VEC_W-1:0] out_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q;
    logic             err_q;
    logic [15:0]      cnt_q;
    logic             at_last;
    logic             accept;
    logic             close;
    logic             bad;
    logic             frame_done;

    logicnet_quantizer2 #(
        .IN_WIDTH (IN_WIDTH),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3)
    ) u_quant (
        .x    (s_data),
        .code (code)
    );

    assign at_last = (idx_q == LAST_IDX);
    // Only the closing beat can stall: it needs the output register free or draining.
    assign s_ready = !(at_last && valid_q && !m_ready);
    assign accept  = s_valid && s_ready;

`ifdef INPUT_PACKER_FRAME_CHECK_EN
    assign bad   = accept && (s_last != at_last);
    assign close = accept && (at_last || s_last);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign bad   = 1'b0;
    assign close = accept && at_last;
`endif

    assign frame_done = close && !bad;

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (accept) begin
            acc_d[ACT_BITS*idx_q +: ACT_BITS] = code;
            idx_d = close ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            err_q <= bad;
            // A completing frame wins over a drain so back-to-back frames keep m_valid high.
            if (frame_done) begin
                out_q   <= acc_d;
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + 16'd1;
            end else if (m_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = out_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Scoreboard bench for logicnet_input_packer with NUM_FEATURES=4 and default thresholds.
module tb_logicnet_input_packer;

    localparam int unsigned N  = 4;
    localparam int unsigned T1 = 64;
    localparam int unsigned T2 = 128;
    localparam int unsigned T3 = 192;

    typedef struct packed {
        logic [2*N-1:0] data;
        logic [15:0]    cnt;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [7:0]     s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [2*N-1:0] m_data;
    logic           frame_err;
    logic [15:0]    frame_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mr_rand = 0;

    // Reference model state
    int unsigned part[$];
    frame_t      exp_q[$];
    bit          out_full = 0;
    bit          err_pend = 0;
    logic [15:0] exp_cnt  = '0;

    logicnet_input_packer #(
        .NUM_FEATURES (N),
        .IN_WIDTH     (8),
        .T1           (T1),
        .T2           (T2),
        .T3           (T3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned ref_code(input int unsigned x);
        return int'(x >= T1) + int'(x >= T2) + int'(x >= T3);
    endfunction

    // Input-side model: observes handshakes just after the falling edge.
    always @(negedge clk) begin
        bit          stall;
        bit          bad;
        bit          fin;
        int unsigned v;
        #1;
        if (!rst_n) begin
            check("rst_s_ready", s_ready, 1);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            part.delete();
            exp_q.delete();
            out_full = 0;
            err_pend = 0;
            exp_cnt  = '0;
        end else begin
            check("frame_err", frame_err, err_pend);
            err_pend = 0;
            check("m_valid", m_valid, out_full);
            stall = (part.size() == N - 1) && out_full && !m_ready;
            check("s_ready", s_ready, !stall);
            fin = 0;
            if (s_valid && !stall) begin
                bad = 0;
`ifdef INPUT_PACKER_FRAME_CHECK_EN
                bad = (s_last != (part.size() == N - 1));
`endif
                if (bad) begin
                    err_pend = 1;
                    part.delete();
                end else begin
                    part.push_back(ref_code(s_data));
                    if (part.size() == N) begin
                        v = 0;
                        for (int i = 0; i < N; i++) v += part[i] << (2 * i);
                        exp_cnt = exp_cnt + 16'd1;
                        exp_q.push_back('{data: (2*N)'(v), cnt: exp_cnt});
                        part.delete();
                        fin = 1;
                    end
                end
            end
            out_full = fin ? 1'b1 : (m_ready ? 1'b0 : out_full);
        end
    end

    // Output monitor: compares every presented frame against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got %0h, expected none", m_data);
            end else begin
                check("m_data", m_data, exp_q[0].data);
                check("frame_cnt", frame_cnt, exp_q[0].cnt);
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) if (mr_rand) m_ready = 1'($urandom_range(0, 1));

    task automatic beat(input logic [7:0] d, input logic last);
        int waited = 0;
        bit done   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!done) begin
            #1;
            done = s_ready;
            @(negedge clk);
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_timeout: got s_ready=0 for %0d cycles, expected <=50", waited);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b0);
        beat(d, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        frame(8'd0, 8'd64, 8'd191, 8'd255);
        idle(3);
        frame(8'd63, 8'd127, 8'd128, 8'd192);
        idle(3);

        // Hold one frame, then stall the second on its closing beat.
        m_ready = 1'b0;
        frame(8'd0, 8'd64, 8'd128, 8'd255);
        fork
            frame(8'd200, 8'd100, 8'd10, 8'd70);
            begin
                repeat (10) @(negedge clk);
                m_ready = 1'b1;
            end
        join
        idle(3);

        for (int f = 0; f < 8; f++)
            frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        idle(3);

`ifdef INPUT_PACKER_FRAME_CHECK_EN
        beat(8'd200, 1'b0);
        beat(8'd90, 1'b1);
        idle(2);
        frame(8'd1, 8'd70, 8'd150, 8'd250);
        beat(8'd5, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd5, 1'b0);
        idle(2);
        frame(8'd250, 8'd150, 8'd70, 8'd1);
        idle(3);
`endif

        beat(8'd255, 1'b0);
        beat(8'd255, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame(8'd130, 8'd0, 8'd255, 8'd65);
        idle(3);

        mr_rand = 1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                beat(8'($urandom_range(0, 255)), 1'(i == N - 1));
            end
        end
        mr_rand = 0;
        m_ready = 1'b1;
        idle(10);
        check("drain_empty", exp_q.size(), 0);
        check("final_frame_cnt", frame_cnt, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
